lsu_mem_ctrl: RTL
=================

# lsu_mem_ctrl

Load/store unit between the CPU execute stage and the data `Memory` block. It accepts one byte-addressed load or store per handshake and converts it to the memory's word-index, lane-select, `str` and `ld` controls. Alignment and range checks happen before any memory access. Load data is lane-extracted and sign- or zero-extended before it goes back to the core.

## Interface
Parameters:
- `DEPTH`, 1024: number of 32-bit words in the data memory; word indices at or above `DEPTH` are out of range.
- `AW`, 22: byte-address width; word index = `req_addr[AW-1:2]`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `clr_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request this cycle.
- `req_op`  in  3  operation code, see Structure.
- `req_addr`  in  AW  byte address.
- `req_wdata`  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  32  extended load result; 0 for stores and errors.
- `resp_err`  out  1  misaligned or out-of-range; qualified by `resp_valid`.
- `mem_str`  out  1  to memory `str`.
- `mem_ld`  out  1  to memory `ld`.
- `mem_sel`  out  4  to memory `sel`.
- `mem_addr`  out  20  to memory `addr`, word index, zero-extended.
- `mem_wdata`  out  32  to memory `data_in`.
- `mem_rdata`  in  32  from memory `data_out`; combinational, masked by `ld`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, register op, addr and wdata, and check the request.
  - Misaligned: LW/SW with addr[1:0]≠0; LH/LHU/SH with addr[0]=1.
  - Out of range: word index ≥ `DEPTH`.
  - A request failing either check sets the error flag and goes to RESP.
  - A request passing both checks goes to ACCESS.
- ACCESS:
  - Drives the memory controls from the registered request.
  - Stores: `mem_str`=1. Loads: `mem_ld`=1.
  - `mem_sel` by lane: byte at addr[1:0]=0..3 → 0001/0010/0100/1000; half at addr[1]=0/1 → 0011/1100; word → 1111.
  - `mem_wdata` = registered `req_wdata`, unshifted. The memory takes the byte from [7:0] and the half from [15:0] for every lane.
  - Loads: extract the lane from `mem_rdata` and register it as `resp_rdata`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
  - Always → RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then → IDLE. `req_ready`=0 in ACCESS and RESP.
- Memory controls: `mem_str`, `mem_ld`, `mem_sel` are 0 outside ACCESS. `mem_addr` and `mem_wdata` hold their last registered value.
- Errored requests never assert `mem_str` or `mem_ld`.

## Timing
- Request accepted at edge N (`req_valid`&`req_ready`).
- Valid access: memory controls asserted during cycle N+1. A store commits to memory at edge N+2. `resp_valid` is high during cycle N+2.
- Error: `resp_valid` is high during cycle N+1, with `resp_err`=1.
- Throughput: one valid request per 3 cycles. `req_ready` returns to 1 in cycle N+3 (valid access) or N+2 (error).
- Reset (`clr_n`=0 at an edge), from any state including mid-ACCESS:
  - State → IDLE.
  - All outputs 0 the following cycle: `resp_valid`, `resp_err`, `resp_rdata`, `mem_str`, `mem_ld`, `mem_sel`, `mem_addr`, `mem_wdata`.
  - `req_ready`=1 once out of reset.
  - A store whose ACCESS cycle coincides with the reset edge still commits; it is not cancelled, because the memory samples `str` at that same edge.
- `req_valid` held high across RESP does not re-accept until IDLE. Inputs are sampled only at acceptance.

## Structure
- Shared package `lsu_pkg`:
  - Op encodings: LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7.
  - Size constants BYTE/HALF/WORD.
  - State enum IDLE/ACCESS/RESP.
  - `is_store` and `is_signed` helper functions.
- One sub-module: `lsu_lane_ext`, combinational. Inputs: word, addr[1:0], op. Output: extended 32-bit result. Reused for the sel decode.

## Test plan
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → `mem_sel`=1111 and `mem_addr`=4 in the store's ACCESS cycle; the load's `resp_rdata`=0xDEADBEEF, `resp_err`=0.
- SB 0x13 data 0x000000AB over word 0x11223344, then LB 0x13 and LBU 0x13 → `mem_sel`=1000; LB gives 0xFFFFFFAB, LBU gives 0x000000AB.
- SH 0x22 data 0x8001, then LH 0x22 / LHU 0x22 → `mem_sel`=1100; LH gives 0xFFFF8001, LHU gives 0x00008001.
- Error checks; each gives `resp_err`=1 at N+1 with `mem_str`/`mem_ld` never asserted:
  - LW 0x5 (misaligned).
  - LH 0x3 (misaligned).
  - SW 0x1000 (word index 1024, out of range).
- Back-to-back `req_valid` held high → accepts spaced exactly 3 cycles apart; `resp_valid` is a single-cycle pulse per request.
- `clr_n` low during the ACCESS cycle of an LW → next cycle all outputs 0 and state IDLE; `resp_valid` never pulses for that request.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op encodings, access sizes,
// controller states and small op-decode helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        LW  = 3'd0,
        LH  = 3'd1,
        LHU = 3'd2,
        LB  = 3'd3,
        LBU = 3'd4,
        SW  = 3'd5,
        SH  = 3'd6,
        SB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    function automatic logic is_store(input op_e op);
        return op inside {SW, SH, SB};
    endfunction

    function automatic logic is_signed(input op_e op);
        return op inside {LH, LB};
    endfunction

    function automatic size_e op_size(input op_e op);
        case (op)
            LW, SW:      return WORD;
            LH, LHU, SH: return HALF;
            default:     return BYTE;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_ext.sv
// Lane decode for one access: byte-lane select for the memory and the
// lane-extracted, sign/zero-extended load result.
module lsu_lane_ext
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  op_e         op,
    output logic [31:0] ext,
    output logic [3:0]  sel
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        ext    = word;
        sel    = 4'b1111;
        byte_v = word[{addr_lo, 3'b000} +: 8];
        half_v = addr_lo[1] ? word[31:16] : word[15:0];
        unique case (op_size(op))
            BYTE: begin
                sel = 4'b0001 << addr_lo;
                ext = is_signed(op) ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
            end
            HALF: begin
                sel = addr_lo[1] ? 4'b1100 : 4'b0011;
                ext = is_signed(op) ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: accepts one byte-addressed request per handshake, checks
// alignment/range, drives one memory access cycle and returns a response pulse.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 22
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic          mem_str,
    output logic          mem_ld,
    output logic [3:0]    mem_sel,
    output logic [19:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [31:0] DEPTH_U = DEPTH;

    state_e        state, state_nxt;
    op_e           op_q;
    op_e           req_op_e;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q, rdata_q, ext;
    logic [3:0]    sel;
    logic          err_q, accept, misaligned, out_of_range, req_err;

    assign req_op_e = op_e'(req_op);
    assign accept   = (state == IDLE) && req_valid;

    always_comb begin
        misaligned = 1'b0;
        unique case (op_size(req_op_e))
            WORD:    misaligned = |req_addr[1:0];
            HALF:    misaligned = req_addr[0];
            default: misaligned = 1'b0;
        endcase
    end

    assign out_of_range = 32'(req_addr[AW-1:2]) >= DEPTH_U;
    assign req_err      = misaligned || out_of_range;

    lsu_lane_ext u_lane_ext (
        .word    (mem_rdata),
        .addr_lo (addr_q[1:0]),
        .op      (op_q),
        .ext     (ext),
        .sel     (sel)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!clr_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_str    = 1'b0;
        mem_ld     = 1'b0;
        mem_sel    = 4'b0000;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_err ? RESP : ACCESS;
            end
            ACCESS: begin
                mem_str   = is_store(op_q);
                mem_ld    = !is_store(op_q);
                mem_sel   = sel;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are captured only at acceptance; load data lands during ACCESS.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            op_q    <= LW;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else if (accept) begin
            op_q    <= req_op_e;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= req_err;
            rdata_q <= '0;
        end else if (state == ACCESS && !is_store(op_q)) begin
            rdata_q <= ext;
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q && (state == RESP);
    assign mem_addr   = 20'(addr_q[AW-1:2]);
    assign mem_wdata  = wdata_q;

endmodule
